// File: rtl/prog_loader.sv
// Byte-stream program loader: packs byte pairs into RAM words at consecutive
// addresses and holds the CPU in reset until done. Optional PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [WORD_W-1:0] ram_w_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              ovf,
  output logic [ADDR_W:0]   word_count,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WR,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          lo_q, lo_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [WORD_W-1:0]   w_data_q, w_data_d;
  logic [CNT_W-1:0]    wc_q, wc_d;
  logic                ovf_q, ovf_d;
  logic                xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
  logic                err_q, err_d;
`endif

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      lo_q     <= '0;
      last_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      wc_q     <= '0;
      ovf_q    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      lo_q     <= lo_d;
      last_q   <= last_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      wc_q     <= wc_d;
      ovf_q    <= ovf_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
      err_q    <= err_d;
`endif
    end
  end

  // Handshake is a pure decode of the state register; in_valid never feeds in_ready.
`ifdef PROG_LOADER_CHECKSUM_EN
  assign in_ready = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_CHK);
`else
  assign in_ready = (state_q == S_LO) || (state_q == S_HI);
`endif
  assign xfer = in_valid && in_ready;

  // NOTE: every _d gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    lo_d     = lo_q;
    last_d   = last_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    wc_d     = wc_q;
    ovf_d    = ovf_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d = S_LO;
          addr_d  = start_addr;
          wc_d    = '0;
          ovf_d   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_LO: begin
        if (xfer) begin
          lo_d = in_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_byte;
`endif
          if (in_last) begin
            w_data_d = {8'h00, in_byte};
            w_addr_d = addr_q;
            last_d   = 1'b1;
            state_d  = S_WR;
          end else begin
            last_d  = 1'b0;
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (xfer) begin
          w_data_d = {in_byte, lo_q};
          w_addr_d = addr_q;
          last_d   = in_last;
          state_d  = S_WR;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d   = csum_q ^ in_byte;
`endif
        end
      end
      S_WR: begin
        wc_d = wc_q + CNT_W'(1);
        if (last_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else if (addr_q == {ADDR_W{1'b1}}) begin
          // Address never wraps: a full RAM ends the load with overflow.
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_LO;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          err_d   = (in_byte != csum_q);
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_w_en   = (state_q == S_WR);
  assign ram_w_addr = w_addr_q;
  assign ram_w_data = w_data_q;
  assign cpu_hold   = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign ovf        = ovf_q;
  assign word_count = wc_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule
